sprite_buffer_loader: RTL and testbench
=======================================

Name: sprite_buffer_loader

Overview:
- Fills the flat per-colour sprite bit-buffers that the VGA sprite reader consumes (BUFFER_R/G/B, index = row*LARGURA + col, ascending range [0:400]).
- Accepts a row-major pixel stream over a valid/ready handshake into a shadow copy.
- Publishes shadow and dimensions atomically on a frame-end pulse, so the reader never shows a half-loaded sprite.
- Sits between the sprite ROM/UART source and the reader.

Parameters:
- MAX_PIXELS, 401: buffer depth in bits; a load is legal only if LARGURA*ALTURA <= MAX_PIXELS.
- DIM_W, 10: width of the dimension inputs and outputs.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle load request, sampled only in IDLE.
- LARGURA_IN  in  DIM_W  sprite width in pixels, latched on accepted START.
- ALTURA_IN  in  DIM_W  sprite height in pixels, latched on accepted START.
- PIX_VALID  in  1  stream pixel present.
- PIX_R, PIX_G, PIX_B  in  1 each  pixel colour bits.
- PIX_READY  out  1  loader accepts a pixel this cycle.
- FRAME_END  in  1  one-cycle pulse at end of the visible frame; this is the commit point.
- ABORT  in  1  cancels LOAD or WAIT_COMMIT.
- BUFFER_R, BUFFER_G, BUFFER_B  out  [0:MAX_PIXELS-1]  published buffers.
- LARGURA_OBJETO, ALTURA_OBJETO  out  DIM_W  published dimensions.
- BUSY  out  1  high in LOAD and WAIT_COMMIT.
- DONE  out  1  one-cycle pulse after a commit.
- ERRO  out  1  one-cycle pulse when a START is rejected.

Behaviour:
Reset:
- Asynchronous, active-high, on CLK domain: state=IDLE.
- Shadow and published buffers all 0; dimensions 0; index 0.
- PIX_READY=0, BUSY=0, DONE=0, ERRO=0.

States: IDLE, LOAD, WAIT_COMMIT.

IDLE:
- On START, compute total = LARGURA_IN*ALTURA_IN at 2*DIM_W bits, so there is no truncation.
- If either dimension is 0, or total > MAX_PIXELS: ERRO=1 next cycle, stay IDLE, published outputs unchanged.
- Otherwise: latch dimensions and total, clear all shadow bits to 0, index=0, go to LOAD.

LOAD:
- PIX_READY=1 (registered, asserted the cycle after entry).
- On PIX_VALID&&PIX_READY: shadow_R/G/B[index] <= PIX_R/G/B.
- If index==total-1, go to WAIT_COMMIT with PIX_READY=0 from the next cycle; else index+1.
- Exactly `total` pixels are accepted. PIX_VALID with READY low is ignored and not consumed.

WAIT_COMMIT:
- On FRAME_END: copy shadow to published buffers, latched dims to LARGURA_OBJETO/ALTURA_OBJETO, DONE=1 next cycle, go to IDLE.
- Published outputs change only on this edge.

Boundary conditions:
- START outside IDLE: ignored, no ERRO.
- FRAME_END in IDLE or LOAD: ignored.
- FRAME_END in the same cycle as the last pixel accepted: no commit; waits for the next FRAME_END.
- ABORT in LOAD or WAIT_COMMIT: back to IDLE next cycle, shadow discarded, published outputs unchanged, no DONE.
- ABORT has priority over FRAME_END in the same cycle.
- ABORT in IDLE: no effect.
- Reset mid-load: everything returns to reset values immediately, including published buffers.
- Index width is ceil(log2(MAX_PIXELS)) = 9 bits; compare against total-1 at full width.
- Unwritten bits (index >= total) remain 0 in every published buffer.

Decomposition:
- Shared package sprite_pkg holds: MAX_PIXELS, DIM_W, IDX_W (=9), state encoding (IDLE=2'd0, LOAD=2'd1, WAIT_COMMIT=2'd2).
- The reader adopts the same constants.
- One natural sub-module: sprite_shadow_bank. It holds the 3×MAX_PIXELS shadow and published registers with clear, write-at-index and commit-copy controls.
- The FSM, counters and size check stay in the top.

Test Plan:
- Basic load and commit: reset, START with 4×3, stream 12 pixels with R=index[0], G=1, B=0, then FRAME_END. Expect DONE pulse; BUFFER_R[0:11]=010101010101; BUFFER_G[0:11] all 1; bits 12..400 = 0; LARGURA_OBJETO=4, ALTURA_OBJETO=3.
- Rejected sizes: START 21×20 (420>401) -> ERRO pulse, BUSY=0, outputs unchanged. START 0×5 -> ERRO. START 401×1 -> accepted, BUSY=1.
- Handshake gaps: toggle PIX_VALID every other cycle during a 2×2 load. Expect exactly 4 accepts. PIX_READY=0 after the 4th; a 5th valid pixel is not consumed; outputs are unchanged until FRAME_END.
- Commit timing: FRAME_END during LOAD and on the last-pixel cycle -> no change. The next FRAME_END -> commit, DONE one cycle later.
- Abort: load 3×3, then ABORT after 5 pixels -> IDLE, previously published 4×3 sprite intact. ABORT together with FRAME_END in WAIT_COMMIT -> no commit.
- Reset mid-operation: assert reset asynchronously during LOAD -> all buffers 0, dimensions 0, BUSY=0 without waiting for a clock edge.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: constants shared by the sprite loader and the VGA sprite reader.
//   MAX_PIXELS  depth of each per-colour buffer (index = row*width + col)
//   DIM_W       width of the sprite dimension fields
//   IDX_W       width of the pixel index, ceil(log2(MAX_PIXELS))
//   TOT_W       width of width*height, wide enough that the product never truncates
package sprite_pkg;

  localparam int MAX_PIXELS = 401;
  localparam int DIM_W      = 10;
  localparam int IDX_W      = 9;
  localparam int TOT_W      = 2 * DIM_W;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] LOAD        = 2'd1;
  localparam logic [1:0] WAIT_COMMIT = 2'd2;

  // A sprite fits only if both sides are non-zero and the area fits the buffer.
  function automatic logic size_ok(input logic [DIM_W-1:0] w,
                                   input logic [DIM_W-1:0] h,
                                   input logic [TOT_W-1:0] total);
    return (w != '0) && (h != '0) && (total <= TOT_W'(MAX_PIXELS));
  endfunction

endpackage

// File: rtl/sprite_buffer_loader_shadow_bank.sv
// sprite_shadow_bank: shadow and published copies of the three colour buffers.
//   CLK, reset           clock, async active-high reset (clears everything)
//   clr                  zero all shadow bits
//   wr_en/wr_idx/wr_*    write one pixel's colour bits into the shadow
//   commit               copy the whole shadow into the published buffers
//   pub_r/pub_g/pub_b    published buffers seen by the reader
module sprite_shadow_bank
  import sprite_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  wr_r,
  input  logic                  wr_g,
  input  logic                  wr_b,
  input  logic                  commit,
  output logic [0:MAX_PIXELS-1] pub_r,
  output logic [0:MAX_PIXELS-1] pub_g,
  output logic [0:MAX_PIXELS-1] pub_b
);

  logic [0:MAX_PIXELS-1] shadow_r_q, shadow_g_q, shadow_b_q;
  logic [0:MAX_PIXELS-1] shadow_r_d, shadow_g_d, shadow_b_d;
  logic [0:MAX_PIXELS-1] pub_r_q, pub_g_q, pub_b_q;
  logic [0:MAX_PIXELS-1] pub_r_d, pub_g_d, pub_b_d;

  always_comb begin
    shadow_r_d = shadow_r_q;
    shadow_g_d = shadow_g_q;
    shadow_b_d = shadow_b_q;
    pub_r_d    = pub_r_q;
    pub_g_d    = pub_g_q;
    pub_b_d    = pub_b_q;
    if (clr) begin
      shadow_r_d = '0;
      shadow_g_d = '0;
      shadow_b_d = '0;
    end else if (wr_en) begin
      shadow_r_d[wr_idx] = wr_r;
      shadow_g_d[wr_idx] = wr_g;
      shadow_b_d[wr_idx] = wr_b;
    end
    if (commit) begin
      pub_r_d = shadow_r_q;
      pub_g_d = shadow_g_q;
      pub_b_d = shadow_b_q;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      shadow_r_q <= '0;
      shadow_g_q <= '0;
      shadow_b_q <= '0;
      pub_r_q    <= '0;
      pub_g_q    <= '0;
      pub_b_q    <= '0;
    end else begin
      shadow_r_q <= shadow_r_d;
      shadow_g_q <= shadow_g_d;
      shadow_b_q <= shadow_b_d;
      pub_r_q    <= pub_r_d;
      pub_g_q    <= pub_g_d;
      pub_b_q    <= pub_b_d;
    end
  end

  assign pub_r = pub_r_q;
  assign pub_g = pub_g_q;
  assign pub_b = pub_b_q;

endmodule

// File: rtl/sprite_buffer_loader.sv
// sprite_buffer_loader: loads a row-major pixel stream into a shadow buffer and
// publishes it, with its dimensions, atomically on the next frame-end pulse.
//   CLK, reset                        clock, async active-high reset
//   START, LARGURA_IN, ALTURA_IN      load request and sprite size (IDLE only)
//   PIX_VALID, PIX_R/G/B, PIX_READY   pixel stream handshake
//   FRAME_END                         commit point
//   ABORT                             drop the load in progress
//   BUFFER_R/G/B, LARGURA_OBJETO,
//   ALTURA_OBJETO                     published sprite
//   BUSY, DONE, ERRO                  status (DONE/ERRO are one-cycle pulses)
//
// state       | meaning
// IDLE        | waiting for START; size check on START
// LOAD        | accepting pixels into the shadow until `total` are in
// WAIT_COMMIT | shadow complete; publish on next FRAME_END
module sprite_buffer_loader
  import sprite_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  START,
  input  logic [DIM_W-1:0]      LARGURA_IN,
  input  logic [DIM_W-1:0]      ALTURA_IN,
  input  logic                  PIX_VALID,
  input  logic                  PIX_R,
  input  logic                  PIX_G,
  input  logic                  PIX_B,
  output logic                  PIX_READY,
  input  logic                  FRAME_END,
  input  logic                  ABORT,
  output logic [0:MAX_PIXELS-1] BUFFER_R,
  output logic [0:MAX_PIXELS-1] BUFFER_G,
  output logic [0:MAX_PIXELS-1] BUFFER_B,
  output logic [DIM_W-1:0]      LARGURA_OBJETO,
  output logic [DIM_W-1:0]      ALTURA_OBJETO,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERRO
);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [DIM_W-1:0] larg_q, larg_d, alt_q, alt_d;
  logic [DIM_W-1:0] larg_obj_q, larg_obj_d, alt_obj_q, alt_obj_d;
  logic             pix_ready_q, pix_ready_d;
  logic             done_q, done_d;
  logic             erro_q, erro_d;

  logic [TOT_W-1:0] total_req;
  logic             last_pix;
  logic             accept;
  logic             bank_clr, bank_wr, bank_commit;

  assign total_req = TOT_W'(LARGURA_IN) * TOT_W'(ALTURA_IN);
  // Compare at the full product width so a large total never aliases the index.
  assign last_pix  = (TOT_W'(idx_q) == (total_q - TOT_W'(1)));
  assign accept    = PIX_VALID && pix_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    total_d     = total_q;
    larg_d      = larg_q;
    alt_d       = alt_q;
    larg_obj_d  = larg_obj_q;
    alt_obj_d   = alt_obj_q;
    pix_ready_d = pix_ready_q;
    done_d      = 1'b0;
    erro_d      = 1'b0;
    bank_clr    = 1'b0;
    bank_wr     = 1'b0;
    bank_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (size_ok(LARGURA_IN, ALTURA_IN, total_req)) begin
            larg_d      = LARGURA_IN;
            alt_d       = ALTURA_IN;
            total_d     = total_req;
            idx_d       = '0;
            bank_clr    = 1'b1;
            pix_ready_d = 1'b1;
            state_d     = LOAD;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (ABORT) begin
          pix_ready_d = 1'b0;
          state_d     = IDLE;
        end else if (accept) begin
          bank_wr = 1'b1;
          if (last_pix) begin
            pix_ready_d = 1'b0;
            state_d     = WAIT_COMMIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WAIT_COMMIT: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (FRAME_END) begin
          bank_commit = 1'b1;
          larg_obj_d  = larg_q;
          alt_obj_d   = alt_q;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        pix_ready_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      total_q     <= '0;
      larg_q      <= '0;
      alt_q       <= '0;
      larg_obj_q  <= '0;
      alt_obj_q   <= '0;
      pix_ready_q <= 1'b0;
      done_q      <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      total_q     <= total_d;
      larg_q      <= larg_d;
      alt_q       <= alt_d;
      larg_obj_q  <= larg_obj_d;
      alt_obj_q   <= alt_obj_d;
      pix_ready_q <= pix_ready_d;
      done_q      <= done_d;
      erro_q      <= erro_d;
    end
  end

  sprite_shadow_bank u_bank (
    .CLK    (CLK),
    .reset  (reset),
    .clr    (bank_clr),
    .wr_en  (bank_wr),
    .wr_idx (idx_q),
    .wr_r   (PIX_R),
    .wr_g   (PIX_G),
    .wr_b   (PIX_B),
    .commit (bank_commit),
    .pub_r  (BUFFER_R),
    .pub_g  (BUFFER_G),
    .pub_b  (BUFFER_B)
  );

  assign PIX_READY      = pix_ready_q;
  assign BUSY           = (state_q != IDLE);
  assign DONE           = done_q;
  assign ERRO           = erro_q;
  assign LARGURA_OBJETO = larg_obj_q;
  assign ALTURA_OBJETO  = alt_obj_q;

endmodule

// File: tb/tb_sprite_buffer_loader.sv
module tb_sprite_buffer_loader;

  localparam int N = 401;

  logic          CLK = 1'b0;
  logic          reset;
  logic          START;
  logic [9:0]    LARGURA_IN, ALTURA_IN;
  logic          PIX_VALID, PIX_R, PIX_G, PIX_B, PIX_READY;
  logic          FRAME_END, ABORT;
  logic [0:N-1]  BUFFER_R, BUFFER_G, BUFFER_B;
  logic [9:0]    LARGURA_OBJETO, ALTURA_OBJETO;
  logic          BUSY, DONE, ERRO;

  always #5 CLK = ~CLK;

  sprite_buffer_loader dut (
    .CLK(CLK), .reset(reset), .START(START),
    .LARGURA_IN(LARGURA_IN), .ALTURA_IN(ALTURA_IN),
    .PIX_VALID(PIX_VALID), .PIX_R(PIX_R), .PIX_G(PIX_G), .PIX_B(PIX_B),
    .PIX_READY(PIX_READY), .FRAME_END(FRAME_END), .ABORT(ABORT),
    .BUFFER_R(BUFFER_R), .BUFFER_G(BUFFER_G), .BUFFER_B(BUFFER_B),
    .LARGURA_OBJETO(LARGURA_OBJETO), .ALTURA_OBJETO(ALTURA_OBJETO),
    .BUSY(BUSY), .DONE(DONE), .ERRO(ERRO)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           is_err;
    logic [0:N-1] r, g, b;
    logic [9:0]   w, h;
  } exp_t;
  exp_t sb[$];

  // Reference model: what the reader should see, and the pending sprite.
  logic [0:N-1] pub_r, pub_g, pub_b, sh_r, sh_g, sh_b;
  logic [9:0]   pub_w, pub_h, m_w, m_h;
  int           m_state;   // 0 idle, 1 loading, 2 waiting for frame end
  int           m_total, m_cnt;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_expect(input bit is_err);
    exp_t e;
    e.is_err = is_err;
    e.r = pub_r; e.g = pub_g; e.b = pub_b;
    e.w = pub_w; e.h = pub_h;
    sb.push_back(e);
  endtask

  task automatic check_pub(input string tag);
    chk({tag, "_r"}, BUFFER_R, pub_r);
    chk({tag, "_g"}, BUFFER_G, pub_g);
    chk({tag, "_b"}, BUFFER_B, pub_b);
    chk({tag, "_w"}, LARGURA_OBJETO, pub_w);
    chk({tag, "_h"}, ALTURA_OBJETO, pub_h);
  endtask

  // Monitor: every DONE/ERRO pulse must match the next queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!reset && (DONE || ERRO)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: DONE=%b ERRO=%b, none expected", DONE, ERRO);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {DONE, ERRO}, e.is_err ? 2'b01 : 2'b10);
        chk("sb_buf_r", BUFFER_R, e.r);
        chk("sb_buf_g", BUFFER_G, e.g);
        chk("sb_buf_b", BUFFER_B, e.b);
        chk("sb_largura", LARGURA_OBJETO, e.w);
        chk("sb_altura", ALTURA_OBJETO, e.h);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_start(input int w, input int h);
    START = 1'b1;
    LARGURA_IN = 10'(w);
    ALTURA_IN  = 10'(h);
    if (m_state == 0) begin
      if (w == 0 || h == 0 || w * h > N) begin
        push_expect(1'b1);
      end else begin
        m_state = 1; m_w = 10'(w); m_h = 10'(h);
        m_total = w * h; m_cnt = 0;
        sh_r = '0; sh_g = '0; sh_b = '0;
      end
    end
    tick();
    START = 1'b0;
  endtask

  // vmode: 0 always valid, 1 every other cycle, 2 random.
  // fmode: 0 no FRAME_END, 1 random FRAME_END, 2 FRAME_END with the last pixel.
  task automatic send_pixels(input int n, input int vmode, input bit pat, input int fmode);
    int acc = 0;
    int cyc = 0;
    bit v, a, r, g, b;
    while (acc < n && cyc < 8 * n + 50) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      if (pat) begin r = m_cnt[0]; g = 1'b1; b = 1'b0; end
      else begin r = 1'($urandom); g = 1'($urandom); b = 1'($urandom); end
      PIX_VALID = v; PIX_R = r; PIX_G = g; PIX_B = b;
      a = v && PIX_READY;
      if (a) begin
        sh_r[m_cnt] = r; sh_g[m_cnt] = g; sh_b[m_cnt] = b;
        m_cnt++; acc++;
        if (m_cnt == m_total) m_state = 2;
      end
      FRAME_END = (fmode == 2 && a && m_cnt == m_total) ||
                  (fmode == 1 && $urandom_range(0, 3) == 0);
      tick();
      cyc++;
    end
    PIX_VALID = 1'b0;
    FRAME_END = 1'b0;
    if (acc < n) begin
      checks++;
      errors++;
      $display("FAIL pixel_timeout: accepted %0d required %0d", acc, n);
    end
  endtask

  task automatic frame_end();
    FRAME_END = 1'b1;
    if (m_state == 2) begin
      pub_r = sh_r; pub_g = sh_g; pub_b = sh_b;
      pub_w = m_w; pub_h = m_h;
      push_expect(1'b0);
      m_state = 0;
    end
    tick();
    FRAME_END = 1'b0;
  endtask

  task automatic do_abort(input bit with_fe);
    ABORT = 1'b1;
    FRAME_END = with_fe;
    m_state = 0;
    tick();
    ABORT = 1'b0;
    FRAME_END = 1'b0;
  endtask

  initial begin
    logic [0:N-1] tmp;
    int w, h;
    reset = 1'b1; START = 0; LARGURA_IN = 0; ALTURA_IN = 0;
    PIX_VALID = 0; PIX_R = 0; PIX_G = 0; PIX_B = 0; FRAME_END = 0; ABORT = 0;
    pub_r = '0; pub_g = '0; pub_b = '0; pub_w = '0; pub_h = '0;
    sh_r = '0; sh_g = '0; sh_b = '0; m_w = '0; m_h = '0;
    m_state = 0; m_total = 0; m_cnt = 0;

    @(negedge CLK);
    check_pub("reset");
    chk("reset_busy", BUSY, 0);
    chk("reset_ready", PIX_READY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_erro", ERRO, 0);
    reset = 1'b0;
    tick();

    // Basic 4x3 load and commit.
    do_start(4, 3);
    chk("basic_busy", BUSY, 1);
    chk("basic_ready", PIX_READY, 1);
    send_pixels(12, 0, 1'b1, 0);
    chk("basic_ready_after", PIX_READY, 0);
    chk("basic_busy_wait", BUSY, 1);
    check_pub("basic_precommit");
    frame_end();
    tmp = BUFFER_R;
    chk("basic_r_0_11", tmp[0:11], 12'b010101010101);
    tmp = BUFFER_G;
    chk("basic_g_0_11", tmp[0:11], 12'hfff);
    chk("basic_g_tail", tmp[12:N-1], '0);
    chk("basic_largura", LARGURA_OBJETO, 4);
    chk("basic_altura", ALTURA_OBJETO, 3);
    chk("basic_busy_idle", BUSY, 0);
    tick();
    chk("basic_done_one_cycle", DONE, 0);

    // Rejected and boundary sizes.
    do_start(21, 20);
    chk("rej_busy", BUSY, 0);
    do_start(0, 5);
    chk("rej0_busy", BUSY, 0);
    tick();
    chk("rej_erro_one_cycle", ERRO, 0);
    check_pub("rej_pub");
    do_start(401, 1);
    chk("max_busy", BUSY, 1);
    do_abort(1'b0);
    chk("max_abort_busy", BUSY, 0);

    // Abort mid-load keeps the 4x3 sprite.
    do_start(3, 3);
    send_pixels(5, 2, 1'b0, 1);
    do_abort(1'b0);
    chk("abort_load_busy", BUSY, 0);
    check_pub("abort_load_pub");

    // 2x2 with gaps, START ignored while loading, FRAME_END on last pixel.
    do_start(2, 2);
    do_start(21, 20);
    send_pixels(4, 1, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      PIX_VALID = 1'b1;
      chk("extra_pixel_ready", PIX_READY, 0);
      tick();
    end
    PIX_VALID = 1'b0;
    check_pub("gap_precommit");
    frame_end();
    check_pub("gap_commit");

    // ABORT beats FRAME_END in WAIT_COMMIT; ABORT in IDLE does nothing.
    do_start(3, 3);
    send_pixels(9, 2, 1'b0, 1);
    do_abort(1'b1);
    chk("abort_fe_busy", BUSY, 0);
    check_pub("abort_fe_pub");
    do_abort(1'b0);
    check_pub("abort_idle_pub");

    // Randomized loads.
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(0, 25);
      h = $urandom_range(0, 25);
      do_start(w, h);
      if (m_state == 1) begin
        send_pixels(m_total, 2, 1'b0, 1);
        if ($urandom_range(0, 3) == 0) do_abort($urandom_range(0, 1) == 1);
        else frame_end();
      end
      tick();
      check_pub("rand_pub");
    end

    // Asynchronous reset in the middle of a load.
    do_start(5, 5);
    send_pixels(3, 0, 1'b0, 0);
    #2;
    reset = 1'b1;
    #1;
    pub_r = '0; pub_g = '0; pub_b = '0; pub_w = '0; pub_h = '0;
    m_state = 0;
    check_pub("async_reset");
    chk("async_reset_busy", BUSY, 0);
    chk("async_reset_ready", PIX_READY, 0);
    @(negedge CLK);
    reset = 1'b0;
    tick();

    // Recovery after reset.
    do_start(2, 3);
    send_pixels(6, 2, 1'b0, 0);
    frame_end();
    tick();
    check_pub("recover_pub");

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
